// File: rtl/writeback_unit.sv
// Writeback stage: in-order two-lane writeback queue retiring one entry per cycle into the register file.
// Optional macro WB_BYPASS_EN: read ports return the youngest queued value for a register ahead of the regfile.
module writeback_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb0_valid,
  input  logic [REG_AW-1:0]                 wb0_reg,
  input  logic [DATA_W-1:0]                 wb0_data,
  input  logic                              wb1_valid,
  input  logic [REG_AW-1:0]                 wb1_reg,
  input  logic [DATA_W-1:0]                 wb1_data,
  output logic                              wb_ready,
  input  logic [REG_AW-1:0]                 rd_addr_a,
  input  logic [REG_AW-1:0]                 rd_addr_b,
  output logic [DATA_W-1:0]                 rd_data_a,
  output logic [DATA_W-1:0]                 rd_data_b,
  output logic [(2**REG_AW)-1:0]            pending_mask,
  output logic                              commit_valid,
  output logic [REG_AW-1:0]                 commit_reg,
  output logic [DATA_W-1:0]                 commit_data,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);
  localparam int NREG  = 2**REG_AW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_AW-1:0] q_reg_q  [FIFO_DEPTH];
  logic [REG_AW-1:0] q_reg_d  [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data_d [FIFO_DEPTH];
  logic [DATA_W-1:0] rf_q     [NREG];
  logic [DATA_W-1:0] rf_d     [NREG];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_alt, slot;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [REG_AW-1:0] commit_reg_q, commit_reg_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic              push0, push1, pop;

  // Two free slots are needed before a cycle may accept both lanes.
  assign wb_ready     = (count_q <= CNT_W'(FIFO_DEPTH - 2));
  assign fifo_count   = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_reg   = commit_reg_q;
  assign commit_data  = commit_data_q;

  always_comb begin : next_state
    push0    = wb_ready && wb0_valid && (wb0_reg != '0);
    push1    = wb_ready && wb1_valid && (wb1_reg != '0);
    pop      = (count_q != '0);
    q_reg_d  = q_reg_q;
    q_data_d = q_data_q;
    rf_d     = rf_q;
    // Lane 1 lands behind lane 0 only when lane 0 actually took a slot.
    wr_alt   = wr_ptr_q + PTR_W'(push0);
    if (push0) begin
      q_reg_d[wr_ptr_q]  = wb0_reg;
      q_data_d[wr_ptr_q] = wb0_data;
    end
    if (push1) begin
      q_reg_d[wr_alt]  = wb1_reg;
      q_data_d[wr_alt] = wb1_data;
    end
    wr_ptr_d       = wr_alt + PTR_W'(push1);
    rd_ptr_d       = rd_ptr_q;
    commit_valid_d = pop;
    commit_reg_d   = commit_reg_q;
    commit_data_d  = commit_data_q;
    if (pop) begin
      rf_d[q_reg_q[rd_ptr_q]] = q_data_q[rd_ptr_q];
      rd_ptr_d                = rd_ptr_q + PTR_W'(1);
      commit_reg_d            = q_reg_q[rd_ptr_q];
      commit_data_d           = q_data_q[rd_ptr_q];
    end
    count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_comb begin : lookup
    slot         = '0;
    pending_mask = '0;
    rd_data_a    = (rd_addr_a == '0) ? '0 : rf_q[rd_addr_a];
    rd_data_b    = (rd_addr_b == '0) ? '0 : rf_q[rd_addr_b];
    // Walk oldest to youngest so later matches override earlier ones.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        pending_mask[q_reg_q[slot]] = 1'b1;
`ifdef WB_BYPASS_EN
        if (rd_addr_a != '0 && q_reg_q[slot] == rd_addr_a) rd_data_a = q_data_q[slot];
        if (rd_addr_b != '0 && q_reg_q[slot] == rd_addr_b) rd_data_b = q_data_q[slot];
`else
        rd_data_a = rd_data_a;
        rd_data_b = rd_data_b;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg_q        <= '{default: '0};
      q_data_q       <= '{default: '0};
      rf_q           <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      q_reg_q        <= q_reg_d;
      q_data_q       <= q_data_d;
      rf_q           <= rf_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
    end
  end
endmodule
